// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERROR_STICKY_EN for a sticky error flag plus the err_type output.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  umbral_alto,
  input  logic [CNT_WIDTH-1:0]  umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  pausa,
  output logic                  error_fifo
`ifdef FIFO_ERROR_STICKY_EN
  ,
  output logic [1:0]            err_type
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_empty;
  logic                  r_almost_full;
  logic                  r_pausa;
  logic                  r_error;

  logic                  w_pop_acc;
  logic                  w_push_acc;
  logic                  w_overflow;
  logic                  w_underflow;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_af_nxt;
  logic                  w_full_nxt;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_pop_acc   = pop & ~r_empty;
  assign w_push_acc  = push & (~r_full | w_pop_acc);
  assign w_overflow  = push & ~w_push_acc;
  assign w_underflow = pop & r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push_acc && !w_pop_acc)
      w_cnt_nxt = r_count + CNT_WIDTH'(1);
    else if (w_pop_acc && !w_push_acc)
      w_cnt_nxt = r_count - CNT_WIDTH'(1);
  end

  assign w_full_nxt = (w_cnt_nxt == DEPTH_C);
  assign w_af_nxt   = (w_cnt_nxt >= umbral_alto);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_acc)
      r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_pausa        <= 1'b0;
    end else begin
      if (w_push_acc)
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop_acc) begin
        r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_data_valid   <= w_pop_acc;
      r_count        <= w_cnt_nxt;
      r_empty        <= (w_cnt_nxt == '0);
      r_full         <= w_full_nxt;
      r_almost_empty <= (w_cnt_nxt <= umbral_bajo);
      r_almost_full  <= w_af_nxt;
      r_pausa        <= w_af_nxt | w_full_nxt;
    end
  end

`ifdef FIFO_ERROR_STICKY_EN
  logic [1:0] r_err_type;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error    <= 1'b0;
      r_err_type <= 2'b00;
    end else begin
      r_error    <= r_error | w_overflow | w_underflow;
      r_err_type <= r_err_type | {w_underflow, w_overflow};
    end
  end

  assign err_type = r_err_type;
`else
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      r_error <= 1'b0;
    else
      r_error <= w_overflow | w_underflow;
  end
`endif

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign count        = r_count;
  assign fifo_empty   = r_empty;
  assign fifo_full    = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign pausa        = r_pausa;
  assign error_fifo   = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: expected read words are queued at issue time and
// checked by an independent monitor whenever data_valid is presented.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [5:0] data_in = '0;
  logic [2:0] umbral_alto = 3'd3;
  logic [2:0] umbral_bajo = 3'd1;
  logic [5:0] data_out;
  logic       data_valid;
  logic [2:0] count;
  logic       fifo_empty, fifo_full, almost_empty, almost_full, pausa, error_fifo;
`ifdef FIFO_ERROR_STICKY_EN
  logic [1:0] err_type;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q [$];

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
    .almost_full(almost_full), .pausa(pausa), .error_fifo(error_fifo)
`ifdef FIFO_ERROR_STICKY_EN
    , .err_type(err_type)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Status snapshot: count, empty, full, almost_empty, almost_full, pausa, error.
  task automatic chk_st(input string name, input int c, input logic e, input logic f,
                        input logic ae, input logic af, input logic pa, input logic er);
    chk({name, ".count"}, 8'(count), 8'(c));
    chk({name, ".empty"}, 8'(fifo_empty), 8'(e));
    chk({name, ".full"}, 8'(fifo_full), 8'(f));
    chk({name, ".aempty"}, 8'(almost_empty), 8'(ae));
    chk({name, ".afull"}, 8'(almost_full), 8'(af));
    chk({name, ".pausa"}, 8'(pausa), 8'(pa));
    chk({name, ".error"}, 8'(error_fifo), 8'(er));
  endtask

  // One clock of stimulus; inputs released 1 time unit after the edge.
  task automatic op(input logic p, input logic q, input logic [5:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic pop_exp(input logic [5:0] d);
    exp_q.push_back(d);
    op(1'b0, 1'b1, 6'h00);
  endtask

  always @(negedge clk) begin
    if (reset_L && data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h with nothing expected", data_out);
      end else begin
        chk("rd_data", 8'(data_out), 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // 1. reset then idle
    repeat (3) @(posedge clk);
    #1 reset_L = 1'b1;
    op(1'b0, 1'b0, 6'h00);
    chk_st("reset", 0, 1, 0, 1, 0, 0, 0);
    chk("reset.data_out", 8'(data_out), 8'h00);
    chk("reset.valid", 8'(data_valid), 8'h0);

    // 2. fill
    op(1'b1, 1'b0, 6'h11); chk_st("fill1", 1, 0, 0, 1, 0, 0, 0);
    op(1'b1, 1'b0, 6'h22); chk_st("fill2", 2, 0, 0, 0, 0, 0, 0);
    op(1'b1, 1'b0, 6'h33); chk_st("fill3", 3, 0, 0, 0, 1, 1, 0);
    op(1'b1, 1'b0, 6'h04); chk_st("fill4", 4, 0, 1, 0, 1, 1, 0);

    // 3. overflow on full
    op(1'b1, 1'b0, 6'h3F); chk_st("ovf", 4, 0, 1, 0, 1, 1, 1);
    op(1'b0, 1'b0, 6'h00);
`ifdef FIFO_ERROR_STICKY_EN
    chk("ovf.sticky", 8'(error_fifo), 8'h1);
`else
    chk("ovf.pulse_end", 8'(error_fifo), 8'h0);
`endif

    // 4. push+pop while full
    exp_q.push_back(6'h11);
    op(1'b1, 1'b1, 6'h2A);
    chk("pp_full.data_out", 8'(data_out), 8'h11);
    chk("pp_full.valid", 8'(data_valid), 8'h1);
`ifdef FIFO_ERROR_STICKY_EN
    chk_st("pp_full", 4, 0, 1, 0, 1, 1, 1);
`else
    chk_st("pp_full", 4, 0, 1, 0, 1, 1, 0);
`endif
    pop_exp(6'h22);
    pop_exp(6'h33);
    pop_exp(6'h04);
    pop_exp(6'h2A);
    chk("drain.count", 8'(count), 8'h0);
    chk("drain.empty", 8'(fifo_empty), 8'h1);

    // 5. underflow, then push+pop on empty
    op(1'b0, 1'b1, 6'h00);
    chk("udf.error", 8'(error_fifo), 8'h1);
    chk("udf.valid", 8'(data_valid), 8'h0);
    chk("udf.count", 8'(count), 8'h0);
    op(1'b1, 1'b1, 6'h15);
    chk("udf_pp.count", 8'(count), 8'h1);
    chk("udf_pp.error", 8'(error_fifo), 8'h1);
    chk("udf_pp.valid", 8'(data_valid), 8'h0);
    pop_exp(6'h15);
`ifdef FIFO_ERROR_STICKY_EN
    chk("udf.sticky", 8'(error_fifo), 8'h1);
    chk("err_type", 8'(err_type), 8'h3);
`else
    chk("udf.pulse_end", 8'(error_fifo), 8'h0);
`endif

    // 6. wrap pointers, then asynchronous reset with count=3
    for (int i = 0; i < 6; i++) begin
      op(1'b1, 1'b0, 6'(8'h20 + i));
      pop_exp(6'(8'h20 + i));
    end
    op(1'b1, 1'b0, 6'h01);
    op(1'b1, 1'b0, 6'h02);
    op(1'b1, 1'b0, 6'h03);
    chk("pre_rst.count", 8'(count), 8'h3);
    #2 reset_L = 1'b0;
    #1;
    chk_st("async_rst", 0, 1, 0, 1, 0, 0, 0);
    chk("async_rst.data_out", 8'(data_out), 8'h00);
    chk("async_rst.valid", 8'(data_valid), 8'h0);
`ifdef FIFO_ERROR_STICKY_EN
    chk("async_rst.err_type", 8'(err_type), 8'h0);
`endif
    @(negedge clk);
    reset_L = 1'b1;
    op(1'b1, 1'b0, 6'h07);
    chk("post_rst.count", 8'(count), 8'h1);
    pop_exp(6'h07);
    chk("post_rst.data_out", 8'(data_out), 8'h07);
    op(1'b0, 1'b0, 6'h00);
    @(negedge clk);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
